// File: rtl/pwm_gen_pkg.sv
// Shared constants and state encoding for the PWM generator.
package pwm_gen_pkg;

  localparam int unsigned CNT_W      = 32;
  localparam int unsigned MIN_PERIOD = 2;

  localparam logic [CNT_W-1:0] DEF_PERIOD = 32'd50000;
  localparam logic [CNT_W-1:0] DEF_DUTY   = 32'd25000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/pwm_gen_cfg.sv
// Config handshake, shadow registers, period clamp and active period/duty.
// Optional duty ramp (one step per period) when PWM_GEN_RAMP_EN is defined.
module pwm_gen_cfg
  import pwm_gen_pkg::*;
#(
  parameter int unsigned      CNT_W      = 32,
  parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(50000),
  parameter logic [CNT_W-1:0] DEF_DUTY   = CNT_W'(25000)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [CNT_W-1:0] i_period,
  input  logic [CNT_W-1:0] i_duty,
  input  logic             i_load,
  output logic [CNT_W-1:0] o_per_act,
  output logic [CNT_W-1:0] o_duty_act
);

  logic             r_pending;
  logic             r_ready;
  logic [CNT_W-1:0] r_sh_per;
  logic [CNT_W-1:0] r_sh_duty;
  logic [CNT_W-1:0] r_per_act;
  logic [CNT_W-1:0] r_duty_act;

  logic             w_accept;
  logic [CNT_W-1:0] w_per_clamp;

  assign w_accept    = i_valid && r_ready;
  assign w_per_clamp = (i_period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : i_period;

`ifdef PWM_GEN_RAMP_EN
  logic [CNT_W-1:0] w_duty_step;

  // Move the active duty one count toward the shadow target.
  always_comb begin
    w_duty_step = r_duty_act;
    if (r_duty_act < r_sh_duty) begin
      w_duty_step = r_duty_act + CNT_W'(1);
    end else if (r_duty_act > r_sh_duty) begin
      w_duty_step = r_duty_act - CNT_W'(1);
    end
  end
`endif

  // Accept only while nothing is pending, so accept and load never collide.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending  <= 1'b0;
      r_ready    <= 1'b1;
      r_sh_per   <= DEF_PERIOD;
      r_sh_duty  <= DEF_DUTY;
      r_per_act  <= DEF_PERIOD;
      r_duty_act <= DEF_DUTY;
    end else if (w_accept) begin
      r_sh_per  <= w_per_clamp;
      r_sh_duty <= i_duty;
      r_pending <= 1'b1;
      r_ready   <= 1'b0;
    end else if (i_load && r_pending) begin
      r_per_act <= r_sh_per;
`ifdef PWM_GEN_RAMP_EN
      r_duty_act <= w_duty_step;
      if (w_duty_step == r_sh_duty) begin
        r_pending <= 1'b0;
        r_ready   <= 1'b1;
      end
`else
      r_duty_act <= r_sh_duty;
      r_pending  <= 1'b0;
      r_ready    <= 1'b1;
`endif
    end
  end

  assign o_ready    = r_ready;
  assign o_per_act  = r_per_act;
  assign o_duty_act = r_duty_act;

endmodule

// File: rtl/pwm_gen.sv
// PWM generator top: IDLE/RUN FSM, period counter and registered outputs.
// Define PWM_GEN_RAMP_EN to ramp duty changes one count per period.
module pwm_gen #(
  parameter int unsigned      CNT_W      = pwm_gen_pkg::CNT_W,
  parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(pwm_gen_pkg::DEF_PERIOD),
  parameter logic [CNT_W-1:0] DEF_DUTY   = CNT_W'(pwm_gen_pkg::DEF_DUTY)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_duty,
  output logic             pwm_out,
  output logic             period_tick
);

  import pwm_gen_pkg::*;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pwm;
  logic             r_tick;

  logic [CNT_W-1:0] w_per_act;
  logic [CNT_W-1:0] w_duty_act;
  logic             w_load;

  // Shadow may load any time in IDLE, otherwise only on the last cycle of a period.
  assign w_load = (r_state == IDLE) || r_tick;

  pwm_gen_cfg #(
    .CNT_W      (CNT_W),
    .DEF_PERIOD (DEF_PERIOD),
    .DEF_DUTY   (DEF_DUTY)
  ) u_cfg (
    .i_clk      (sys_clk),
    .i_rst      (sys_rst),
    .i_valid    (cfg_valid),
    .o_ready    (cfg_ready),
    .i_period   (cfg_period),
    .i_duty     (cfg_duty),
    .i_load     (w_load),
    .o_per_act  (w_per_act),
    .o_duty_act (w_duty_act)
  );

  // r_tick is set one edge early so it is high exactly while r_cnt == per_act-1;
  // period >= 2 guarantees no tick on the cycle right after a wrap or start.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pwm   <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_pwm <= (r_state == RUN) && (r_cnt < w_duty_act);
      if (!enable) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_tick  <= 1'b0;
      end else begin
        r_state <= RUN;
        if (w_load) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        r_tick <= (r_state == RUN) && (r_cnt == w_per_act - CNT_W'(2));
      end
    end
  end

  assign pwm_out     = r_pwm;
  assign period_tick = r_tick;

endmodule

// File: doc/pwm_gen.md
PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 Parameter CNT_W: default 32; width of the period/duty counters and config fields.
REQ-002 Parameter DEF_PERIOD: default 32'd50000; period in sys_clk cycles after reset (1 kHz at 50 MHz).
REQ-003 Parameter DEF_DUTY: default 32'd25000; high-time in sys_clk cycles after reset.
REQ-004 sys_clk  input  1  single clock; all logic on rising edge.
REQ-005 sys_rst  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  1 = generate PWM, 0 = hold idle.
REQ-007 cfg_valid  input  1  new period/duty offered.
REQ-008 cfg_ready  output  1  block can accept a new config.
REQ-009 cfg_period  input  CNT_W  requested period, in cycles.
REQ-010 cfg_duty  input  CNT_W  requested high-time, in cycles.
REQ-011 pwm_out  output  1  registered PWM waveform; feeds the downstream pwm_in two-flop synchroniser.
REQ-012 period_tick  output  1  one-cycle pulse on the last cycle of each period.

Function
REQ-013 The FSM SHALL have two states: IDLE (enable=0) and RUN (enable=1); IDLE->RUN when enable=1, RUN->IDLE when enable=0, taking effect on the next edge.
REQ-014 In RUN, counter cnt SHALL count 0..per_act-1, then wrap to 0; period_tick=1 exactly on the cycle cnt==per_act-1.
REQ-015 pwm_out SHALL be registered as (cnt < duty_act), so pwm_out lags cnt by one cycle.
REQ-016 In IDLE, cnt SHALL be held at 0, and pwm_out and period_tick SHALL be 0.
REQ-017 A config SHALL be accepted on the cycle cfg_valid&&cfg_ready; it is captured into shadow registers and sets the pending flag.
REQ-018 cfg_ready SHALL equal !pending (non-ramp build); cfg_valid with cfg_ready=0 has no effect.
REQ-019 In RUN, a pending shadow SHALL load into per_act/duty_act on the period_tick cycle (new values active from cnt=0); pending clears on the same edge.
REQ-020 In IDLE, a pending shadow SHALL load on the next edge.
REQ-021 A config accepted on the period_tick cycle SHALL be applied at the following wrap, not the current one.
REQ-022 A cfg_period < 2 SHALL be clamped to 2 at capture.
REQ-023 duty_act=0 SHALL give a constant-low output.
REQ-024 duty_act >= per_act SHALL give a constant-high output in RUN.
REQ-025 Counter compares SHALL be unsigned at CNT_W bits; there is no overflow, since cnt < per_act <= 2^CNT_W-1.

Reset
REQ-026 On sys_rst=1 at a clock edge, the block SHALL set: state=IDLE, cnt=0, per_act=DEF_PERIOD, duty_act=DEF_DUTY, pending=0, pwm_out=0, period_tick=0, cfg_ready=1.
REQ-027 Reset asserted mid-period or with a config pending SHALL discard the shadow and restart from the defaults; sys_rst has priority over all other inputs.

Configuration
REQ-028 Macro PWM_GEN_RAMP_EN defined: at each period_tick, duty_act SHALL step by +/-1 toward the shadow duty instead of jumping; per_act loads at the first wrap; pending and cfg_ready=0 hold until duty_act equals the target.
REQ-029 Macro PWM_GEN_RAMP_EN undefined: duty_act SHALL load in one step per REQ-019, and no ramp logic is present.

Structure
REQ-030 The shared package pwm_gen_pkg SHALL hold the CNT_W, DEF_PERIOD and DEF_DUTY constants and the state enum {IDLE, RUN}.
REQ-031 The sub-module pwm_gen_cfg SHALL contain the handshake, the shadow registers, the clamp and the optional ramp; the top level holds the FSM, the counter and the output register.

Verification
REQ-032 Reset, then enable=1 with defaults -> pwm_out high 25000 cycles and low 25000 cycles; period_tick every 50000 cycles.
REQ-033 cfg period=10, duty=3 accepted mid-period -> old waveform completes; the next period gives 3 cycles high and 7 low; cfg_ready returns to 1 on the tick.
REQ-034 Boundary configs duty=0, duty=10 (period=10) and period=1 -> constant low, then constant high, then period clamped to 2 with tick every 2 cycles.
REQ-035 Config accepted on the period_tick cycle, then a second cfg_valid while pending -> the first is applied one wrap later; the second is ignored until cfg_ready=1.
REQ-036 sys_rst pulsed mid-period with a config pending, then enable=1 -> cnt restarts at 0 and the default 25000/50000 waveform resumes.
REQ-037 PWM_GEN_RAMP_EN build, duty 3->6 at period=10 -> duty_act goes 4, 5, 6 over three successive periods, with cfg_ready=0 until duty_act=6.
